// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, stall, flush and a saturating bubble counter.
// Define PIPE_SKID_EN for the 2-entry skid variant with a registered in_ready.
module pipe_stage_reg #(
    parameter int WIDTH = 32,
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [PC_W-1:0]  out_pc,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             main_full;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [PC_W-1:0]  main_pc_q, main_pc_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    assign out_valid  = main_full & ~stall;
    assign out_fire   = out_valid & out_ready;
    assign in_fire    = in_valid & in_ready;
    assign out_data   = main_data_q;
    assign out_pc     = main_pc_q;
    assign bubble_cnt = bubble_cnt_q;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!out_valid && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q  <= '0;
            main_pc_q    <= '0;
            bubble_cnt_q <= '0;
        end else begin
            main_data_q  <= main_data_d;
            main_pc_q    <= main_pc_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

`ifdef PIPE_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [PC_W-1:0]  skid_pc_q, skid_pc_d;

    assign main_full = (state_q != ST_EMPTY);
    // Only stall reaches in_ready combinationally; the state part is a flop.
    assign in_ready  = in_ready_q & ~stall;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_pc_d   = main_pc_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (!stall) begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d     = ST_ONE;
                        main_data_d = in_data;
                        main_pc_d   = in_pc;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                        main_pc_d   = in_pc;
                    end else if (in_fire) begin
                        state_d     = ST_TWO;
                        skid_data_d = in_data;
                        skid_pc_d   = in_pc;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // The skid beat is always younger, so it refills main.
                    if (out_fire) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        main_pc_d   = skid_pc_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            skid_data_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            skid_data_q <= skid_data_d;
            skid_pc_q   <= skid_pc_d;
        end
    end
`else
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t state_q, state_d;

    assign main_full = (state_q == ST_FULL);
    // Held low during reset so no beat is offered to an unready stage.
    assign in_ready  = rst_n & (~main_full | out_ready) & ~stall;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_pc_d   = main_pc_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (!stall) begin
            if (in_fire) begin
                state_d     = ST_FULL;
                main_data_d = in_data;
                main_pc_d   = in_pc;
            end else if (out_fire) begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, directed corner cases and a
// randomized run against a queue-based model of the stage.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int CAP_MAX = 15;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_pc;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_pc;
    logic [3:0]  bubble_cnt;

    pipe_stage_reg #(.WIDTH(32), .PC_W(8), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_pc      (in_pc),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_pc     (out_pc),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [7:0]  pc;
        logic        ordy;
        logic        eov;
        logic        eir;
        logic [7:0]  epc;
        logic [31:0] ed;
        logic [3:0]  ecnt;
    } vec_t;

    int    n_total = 0;
    int    n_pass  = 0;
    beat_t mq[$];
    int    mcnt;
    bit    exp_ov;
    bit    exp_ir;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic [7:0] pc,
                         input logic st, input logic fl, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        in_pc     = pc;
        stall     = st;
        flush     = fl;
        out_ready = ordy;
    endtask

    // Apply one cycle of inputs and compare outputs against the queue model.
    task automatic apply(input logic iv, input logic [31:0] d, input logic [7:0] pc,
                         input logic st, input logic fl, input logic ordy);
        @(negedge clk);
        drive(iv, d, pc, st, fl, ordy);
        #1;
        exp_ov = (mq.size() > 0) && !st;
        if (SKID) exp_ir = (mq.size() < 2) && !st;
        else      exp_ir = ((mq.size() == 0) || ordy) && !st;
        chk("out_valid", out_valid, exp_ov);
        chk("in_ready", in_ready, exp_ir);
        if (mq.size() > 0) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_data", out_data, mq[0].data);
        end
        chk("bubble_cnt", bubble_cnt, mcnt);
    endtask

    // Advance the model by the cycle just applied.
    task automatic commit();
        beat_t b;
        if (!exp_ov && mcnt < CAP_MAX) mcnt++;
        if (flush) begin
            mq.delete();
        end else begin
            if (exp_ov && out_ready) void'(mq.pop_front());
            if (in_valid && exp_ir) begin
                b.pc   = in_pc;
                b.data = in_data;
                mq.push_back(b);
            end
        end
    endtask

    task automatic step(input logic iv, input logic [31:0] d, input logic [7:0] pc,
                        input logic st, input logic fl, input logic ordy);
        apply(iv, d, pc, st, fl, ordy);
        commit();
    endtask

    task automatic finish_reset();
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mq.delete();
        mcnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        finish_reset();
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 32'h00500093, 8'd0,  1'b1, 1'b0, 1'b1, 8'd0,  32'h0,        4'd0};
        tbl[1] = '{1'b1, 32'h00A00113, 8'd4,  1'b1, 1'b1, 1'b1, 8'd0,  32'h00500093, 4'd1};
        tbl[2] = '{1'b1, 32'h002081B3, 8'd8,  1'b1, 1'b1, 1'b1, 8'd4,  32'h00A00113, 4'd1};
        tbl[3] = '{1'b1, 32'h40208233, 8'd12, 1'b1, 1'b1, 1'b1, 8'd8,  32'h002081B3, 4'd1};
        tbl[4] = '{1'b0, 32'h0,        8'd0,  1'b1, 1'b1, 1'b1, 8'd12, 32'h40208233, 4'd1};
        tbl[5] = '{1'b0, 32'h0,        8'd0,  1'b1, 1'b0, 1'b1, 8'd0,  32'h0,        4'd1};

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_pc", out_pc, 8'h0);
        chk("rst_bubble_cnt", bubble_cnt, 4'd0);
        chk("rst_in_ready", in_ready, SKID);
        finish_reset();

        // Four-beat stream with out_ready held high.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(tbl[i].iv, tbl[i].d, tbl[i].pc, 1'b0, 1'b0, tbl[i].ordy);
            #1;
            chk($sformatf("stream%0d_valid", i), out_valid, tbl[i].eov);
            chk($sformatf("stream%0d_ready", i), in_ready, tbl[i].eir);
            chk($sformatf("stream%0d_cnt", i), bubble_cnt, tbl[i].ecnt);
            if (tbl[i].eov) begin
                chk($sformatf("stream%0d_pc", i), out_pc, tbl[i].epc);
                chk($sformatf("stream%0d_data", i), out_data, tbl[i].ed);
            end
        end

        // Back-pressure for three cycles, then release.
        do_reset();
        apply(1'b1, 32'hA0, 8'd0, 1'b0, 1'b0, 1'b0); commit();
        apply(1'b1, 32'hA4, 8'd4, 1'b0, 1'b0, 1'b0);
        chk("bp_ready_2nd", in_ready, SKID);
        commit();
        apply(1'b1, 32'hA8, 8'd8, 1'b0, 1'b0, 1'b0);
        chk("bp_ready_3rd", in_ready, 1'b0);
        commit();
        apply(1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("bp_first_pc", out_pc, 8'd0);
        commit();
        apply(1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("bp_second_valid", out_valid, SKID);
        commit();
        step(1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b1);

        // Flush with both slots occupied and a beat on the input.
        do_reset();
        step(1'b1, 32'hB8, 8'd8, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hBC, 8'd12, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC0, 8'd16, 1'b0, 1'b1, 1'b0);
        apply(1'b1, 32'hC4, 8'd20, 1'b0, 1'b0, 1'b1);
        chk("flush_empty", out_valid, 1'b0);
        commit();
        apply(1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("flush_next_valid", out_valid, 1'b1);
        chk("flush_next_pc", out_pc, 8'd20);
        commit();

        // Two stall cycles with a held beat.
        do_reset();
        step(1'b1, 32'hD4, 8'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 32'hD8, 8'd8, 1'b1, 1'b0, 1'b1);
            chk($sformatf("stall%0d_valid", i), out_valid, 1'b0);
            chk($sformatf("stall%0d_ready", i), in_ready, 1'b0);
            commit();
        end
        apply(1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("stall_release_pc", out_pc, 8'd4);
        chk("stall_release_valid", out_valid, 1'b1);
        chk("stall_bubbles", bubble_cnt, 4'd3);
        commit();

        // Counter saturation.
        do_reset();
        repeat (20) step(1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("sat_cnt", bubble_cnt, 4'd15);
        commit();

        // Asynchronous reset between clock edges.
        do_reset();
        step(1'b1, 32'hE0, 8'd40, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hE4, 8'd44, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_pc", out_pc, 8'h0);
        chk("arst_out_data", out_data, 32'h0);
        chk("arst_bubble_cnt", bubble_cnt, 4'd0);
        chk("arst_in_ready", in_ready, SKID);
        finish_reset();

        // Randomized traffic against the model.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int c = 0; c < 40; c++) begin
                step($urandom_range(0, 9) < 7, $urandom, 8'($urandom),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                     $urandom_range(0, 9) < 6);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
